// File: rtl/logic_gate_lab_pkg.sv
// Shared types and constants for logic_gate_lab: gate mode encoding, LED bit map
// and the gate evaluation helpers used by the top level.
package logic_gate_lab_pkg;

    typedef enum logic [2:0] {
        GATE_AND  = 3'd0,
        GATE_OR   = 3'd1,
        GATE_XOR  = 3'd2,
        GATE_NAND = 3'd3,
        GATE_NOR  = 3'd4,
        GATE_XNOR = 3'd5
    } gate_mode_t;

    localparam int unsigned MODE_COUNT   = 6;
    localparam int unsigned LED_WIDTH    = 6;
    localparam int unsigned LED_RESULT   = 0;
    localparam int unsigned LED_MODE_LSB = 1;
    localparam int unsigned LED_ANY      = 4;
    localparam int unsigned LED_HB       = 5;

    // Encodings 6..7 are unreachable; if they ever appear they behave as AND.
    function automatic logic gate_eval(input gate_mode_t mode, input logic all_set,
                                       input logic any_set, input logic parity);
        logic res;
        case (mode)
            GATE_AND:  res = all_set;
            GATE_OR:   res = any_set;
            GATE_XOR:  res = parity;
            GATE_NAND: res = ~all_set;
            GATE_NOR:  res = ~any_set;
            GATE_XNOR: res = ~parity;
            default:   res = all_set;
        endcase
        return res;
    endfunction

    function automatic gate_mode_t mode_advance(input gate_mode_t mode);
        gate_mode_t nxt;
        case (mode)
            GATE_AND:  nxt = GATE_OR;
            GATE_OR:   nxt = GATE_XOR;
            GATE_XOR:  nxt = GATE_NAND;
            GATE_NAND: nxt = GATE_NOR;
            GATE_NOR:  nxt = GATE_XNOR;
            default:   nxt = GATE_AND;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/logic_gate_lab_if.sv
// Board-side pin bundle for logic_gate_lab: active-low buttons in, active-low LEDs out.
interface logic_gate_lab_if
    import logic_gate_lab_pkg::*;
#(
    parameter int unsigned N_IN = 2
) ();

    logic [N_IN-1:0]      btn;
    logic                 mode_btn;
    logic [LED_WIDTH-1:0] out_led;

    modport master (
        output btn,
        output mode_btn,
        input  out_led
    );

    modport slave (
        input  btn,
        input  mode_btn,
        output out_led
    );

endinterface

// File: rtl/logic_gate_lab_btn_debounce.sv
// Two-flop synchroniser plus counter debouncer for one active-low button.
// o_press pulses for one cycle alongside the first cycle of a debounced press.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn_n,
    output logic o_stable,
    output logic o_press
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic          r_stable;
    logic          r_press;
    logic [CW-1:0] r_cnt;
    logic          w_differ;
    logic          w_accept;

    assign w_differ = r_sync[1] ^ r_stable;
    assign w_accept = w_differ && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync   <= '1;
            r_stable <= 1'b1;
            r_press  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync  <= {r_sync[0], i_btn_n};
            r_press <= w_accept && r_stable;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= r_sync[1];
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_stable = r_stable;
    assign o_press  = r_press;

endmodule

// File: rtl/logic_gate_lab.sv
// Debounced button gate lab: selectable reduction gate over pressed buttons, shown on LEDs.
// Optional heartbeat on led[5] when LOGIC_GATE_LAB_HEARTBEAT_EN is defined.
module logic_gate_lab
    import logic_gate_lab_pkg::*;
#(
    parameter int unsigned N_IN             = 2,
    parameter int unsigned DEBOUNCE_CYCLES  = 270000,
    parameter int unsigned HEARTBEAT_CYCLES = 13500000
) (
    input  logic              clk,
    input  logic              rst_n,
    logic_gate_lab_if.slave   bus
);

    logic [N_IN-1:0]      w_op_stable;
    logic [N_IN-1:0]      w_op_press_unused;
    logic                 w_mode_stable_unused;
    logic                 w_mode_press;
    logic [N_IN-1:0]      w_p;
    gate_mode_t           r_mode;
    gate_mode_t           w_mode_next;
    logic                 w_result;
    logic                 w_hb_lit;
    logic [LED_WIDTH-1:0] w_led_lit;
    logic [LED_WIDTH-1:0] r_out_led;

    for (genvar g = 0; g < N_IN; g++) begin : g_op_db
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_btn_n  (bus.btn[g]),
            .o_stable (w_op_stable[g]),
            .o_press  (w_op_press_unused[g])
        );
    end

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_mode_db (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_btn_n  (bus.mode_btn),
        .o_stable (w_mode_stable_unused),
        .o_press  (w_mode_press)
    );

    assign w_p = ~w_op_stable;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode <= GATE_AND;
        end else begin
            r_mode <= w_mode_next;
        end
    end

    // LEDs are built from the next mode so a press and an operand change
    // landing together appear in one output update.
    always_comb begin
        w_mode_next = r_mode;
        if (w_mode_press) begin
            w_mode_next = mode_advance(r_mode);
        end
        w_result = gate_eval(w_mode_next, &w_p, |w_p, ^w_p);
    end

`ifdef LOGIC_GATE_LAB_HEARTBEAT_EN
    localparam int unsigned HBW = (HEARTBEAT_CYCLES > 2) ? $clog2(HEARTBEAT_CYCLES) : 1;
    localparam logic [HBW-1:0] HB_LAST = HBW'(HEARTBEAT_CYCLES - 1);

    logic [HBW-1:0] r_hb_cnt;
    logic           r_hb;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hb_cnt <= '0;
            r_hb     <= 1'b0;
        end else if (r_hb_cnt == HB_LAST) begin
            r_hb_cnt <= '0;
            r_hb     <= ~r_hb;
        end else begin
            r_hb_cnt <= r_hb_cnt + 1'b1;
        end
    end

    assign w_hb_lit = (r_hb_cnt == HB_LAST) ? ~r_hb : r_hb;
`else
    assign w_hb_lit = 1'b0;
`endif

    always_comb begin
        w_led_lit                   = '0;
        w_led_lit[LED_RESULT]       = w_result;
        w_led_lit[LED_MODE_LSB +: 3] = w_mode_next;
        w_led_lit[LED_ANY]          = |w_p;
        w_led_lit[LED_HB]           = w_hb_lit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_led <= '1;
        end else begin
            r_out_led <= ~w_led_lit;
        end
    end

    assign bus.out_led = r_out_led;

endmodule

// File: tb/tb_logic_gate_lab.sv
// Directed bench for logic_gate_lab with DEBOUNCE_CYCLES=4, HEARTBEAT_CYCLES=8, N_IN=2.
module tb_logic_gate_lab;

    localparam int unsigned N_IN = 2;
    localparam int unsigned DB   = 4;
    localparam int unsigned HB   = 8;
    localparam int unsigned LAT  = 2 + DB + 1;

`ifdef LOGIC_GATE_LAB_HEARTBEAT_EN
    localparam logic [5:0] CMP_MASK = 6'b011111;
`else
    localparam logic [5:0] CMP_MASK = 6'b111111;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    logic_gate_lab_if #(.N_IN(N_IN)) bus ();

    logic_gate_lab #(
        .N_IN             (N_IN),
        .DEBOUNCE_CYCLES  (DB),
        .HEARTBEAT_CYCLES (HB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_checks++;
        if ((got & CMP_MASK) !== (exp & CMP_MASK)) begin
            n_errors++;
            $display("FAIL %s: out_led=%b expected %b", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pins with no operands pressed for modes 1,2,3,4,5,0.
    logic [5:0] mode_exp [6] = '{6'b111101, 6'b111011, 6'b111000,
                                 6'b110110, 6'b110100, 6'b111111};
    logic [5:0] prev;

    initial begin
        bus.btn      = 2'b11;
        bus.mode_btn = 1'b1;
        rst_n        = 1'b0;
        step(3);
        chk("reset", bus.out_led, 6'b111111);
        rst_n = 1'b1;
        step(1);
        chk("post_reset_mode_and", bus.out_led, 6'b111111);

        bus.btn = 2'b00;
        step(LAT - 1);
        chk("and_both_early", bus.out_led, 6'b111111);
        step(1);
        chk("and_both", bus.out_led, 6'b101110);

        bus.btn = 2'b10;
        step(LAT - 1);
        chk("and_one_early", bus.out_led, 6'b101110);
        step(1);
        chk("and_one", bus.out_led, 6'b101111);

        bus.btn = 2'b11;
        step(LAT);
        chk("all_released", bus.out_led, 6'b111111);

        bus.btn = 2'b10;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("glitch_low", bus.out_led, 6'b111111);
        end
        bus.btn = 2'b11;
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk("glitch_after", bus.out_led, 6'b111111);
        end

        prev = 6'b111111;
        for (int k = 0; k < 6; k++) begin
            bus.mode_btn = 1'b0;
            step(LAT - 1);
            chk($sformatf("mode_step%0d_early", k), bus.out_led, prev);
            step(1);
            chk($sformatf("mode_step%0d", k), bus.out_led, mode_exp[k]);
            step(3);
            bus.mode_btn = 1'b1;
            step(10);
            chk($sformatf("mode_step%0d_hold", k), bus.out_led, mode_exp[k]);
            prev = mode_exp[k];
        end

        bus.mode_btn = 1'b0;
        bus.btn      = 2'b10;
        step(LAT - 1);
        chk("simul_early", bus.out_led, 6'b111111);
        step(1);
        chk("simul_or", bus.out_led, 6'b101100);
        bus.mode_btn = 1'b1;
        bus.btn      = 2'b11;
        step(10);
        chk("simul_released", bus.out_led, 6'b111101);

        bus.mode_btn = 1'b0;
        step(LAT);
        chk("hold_to_xor", bus.out_led, 6'b111011);
        rst_n = 1'b0;
        step(1);
        chk("reset_mid_hold", bus.out_led, 6'b111111);
        step(2);
        rst_n = 1'b1;
        step(LAT - 1);
        chk("rehold_early", bus.out_led, 6'b111111);
        step(1);
        chk("rehold_or", bus.out_led, 6'b111101);
        bus.mode_btn = 1'b1;
        step(10);
        chk("rehold_release", bus.out_led, 6'b111101);

`ifdef LOGIC_GATE_LAB_HEARTBEAT_EN
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(HB - 1);
        chk("hb_before_first", {5'b0, bus.out_led[5]}, 6'b000001);
        step(1);
        chk("hb_first_toggle", {5'b0, bus.out_led[5]}, 6'b000000);
        step(HB - 1);
        chk("hb_lit_hold", {5'b0, bus.out_led[5]}, 6'b000000);
        step(1);
        chk("hb_second_toggle", {5'b0, bus.out_led[5]}, 6'b000001);
        step(HB);
        chk("hb_third_toggle", {5'b0, bus.out_led[5]}, 6'b000000);
        step(3);
        rst_n = 1'b0;
        step(1);
        chk("hb_reset_mid", {5'b0, bus.out_led[5]}, 6'b000001);
        rst_n = 1'b1;
        step(2);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/logic_gate_lab.md
# logic_gate_lab

Parametrised successor to the single-gate button/LED exercise. Debounces N_IN active-low push buttons and a dedicated mode button, evaluates one of six selectable reduction gates over the pressed inputs, and drives the board's six active-low LEDs with the result, the current mode and status. It sits directly between the board pins and the LED bank and is the top-level practice block.

## Interface
- N_IN, 2: number of operand buttons; legal range 2..8.
- DEBOUNCE_CYCLES, 270000: consecutive stable cycles required to accept a button change (10 ms at 27 MHz); minimum 2.
- HEARTBEAT_CYCLES, 13500000: half-period of the heartbeat LED, in clock cycles (used only with the heartbeat feature).
- clk  input  1  system clock, single clock domain.
- rst_n  input  1  synchronous, active-low reset.
- btn  input  N_IN  operand buttons, active-low (0 = pressed), asynchronous to clk.
- mode_btn  input  1  mode-select button, active-low, asynchronous.
- out_led  output  6  LEDs, active-low (0 = lit), registered.

## Operation
- Each button (N_IN operands + mode) passes through a 2-flop synchroniser, then a debouncer. Synchroniser flops reset to 1 (released).
- Debouncer: holds `stable` (reset 1). Each cycle, if synced == stable, the counter clears. Otherwise the counter increments, and on the DEBOUNCE_CYCLES-th consecutive differing cycle `stable` takes the synced value and the counter clears. Glitches shorter than DEBOUNCE_CYCLES never reach `stable`.
- Pressed vector p = ~stable for the operand buttons.
- Mode register, 3 bits, reset AND. Order: AND(0), OR(1), XOR(2), NAND(3), NOR(4), XNOR(5).
  - Advances by one on the debounced press edge of mode_btn (stable 1->0).
  - Mode 5 wraps to 0. Values 6..7 are unreachable. If they ever appear, they are treated as AND and the next press loads 0.
- result = reduction of p per mode (&p, |p, ^p, ~&p, ~|p, ~^p).
- LED map, logical 1 = lit, driven inverted:
  - led[0] = result.
  - led[3:1] = mode index in binary.
  - led[4] = |p (any operand pressed).
  - led[5] = heartbeat (see Configuration).
- Reset value of out_led: 6'b111111 (all dark). Counters clear, mode = AND.

## Timing
- Input latency: a raw button level that changes and then holds is reflected on out_led after 2 (sync) + DEBOUNCE_CYCLES (debounce) + 1 (output register) clock edges.
- Mode change: led[3:1] and led[0] reflect the new mode on the same output-register update, 1 cycle after the debounced press edge.
- Simultaneous events: a mode press edge and an operand change in the same cycle are both applied. The LED update uses the new mode with the new p.
- Holding mode_btn pressed advances exactly once. Release has no effect.
- Reset mid-debounce or mid-hold: all state returns to reset values on the next edge with rst_n=0. A button still held at release of reset is re-accepted after the full latency. Its mode press edge counts as a new press.

## Configuration
- LOGIC_GATE_LAB_HEARTBEAT_EN defined:
  - A HEARTBEAT_CYCLES counter toggles led[5] (reset: dark).
  - The first toggle occurs HEARTBEAT_CYCLES cycles after reset release.
- Not defined:
  - led[5] is constant dark (1).
  - The counter and HEARTBEAT_CYCLES logic are absent.

## Structure
- Package logic_gate_lab_pkg:
  - gate_mode_t enum (6 modes, 3 bits) and MODE_COUNT = 6.
  - LED index constants LED_RESULT=0, LED_MODE_LSB=1, LED_ANY=4, LED_HB=5.
- Sub-module btn_debounce (synchroniser + debouncer, parameter DEBOUNCE_CYCLES, outputs `stable` and a one-cycle `press` pulse), instantiated N_IN+1 times.

## Test plan
Bench uses DEBOUNCE_CYCLES=4, HEARTBEAT_CYCLES=8, N_IN=2.
- Reset: hold rst_n=0 for 3 cycles with buttons released -> out_led=6'b111111. After release, led[3:1] shows mode 0 (led[3:1] pins = 3'b111).
- AND mode: press btn=2'b00 -> after 7 edges led[0] pin=0 and led[4] pin=0. Release btn[1] only -> led[0] pin=1 after 7 edges.
- Mode cycling: 6 separate mode_btn presses, each held 10 cycles -> mode steps 1,2,3,4,5,0. In mode 3 (NAND) with no buttons pressed -> led[0] pin=0.
- Glitch rejection: btn[0] low for 3 cycles, then high -> out_led never changes.
- Simultaneous: mode press and btn[0] press start on the same cycle, from AND -> one update shows mode 1 (OR) with led[0] lit.
- Heartbeat: with LOGIC_GATE_LAB_HEARTBEAT_EN, led[5] toggles every 8 cycles. Without it, led[5] stays 1. Asserting reset mid-period returns led[5] to 1.
